// File: rtl/dcache_pkg.sv
// Shared definitions for the 2-way set-associative data cache:
// miss-handling FSM state encodings and derived address-field widths.
package dcache_pkg;

    localparam int STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_MISS      = 3'd1;
    localparam state_t S_WRITEBACK = 3'd2;
    localparam state_t S_REFILL    = 3'd3;
    localparam state_t S_DONE      = 3'd4;

    // Byte-offset bits within one line.
    function automatic int off_w(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    // Set-index bits.
    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    // Tag bits left over after index and offset.
    function automatic int tag_w(input int addr_w, input int line_w, input int sets);
        return addr_w - idx_w(sets) - off_w(line_w);
    endfunction

endpackage

// File: rtl/dcache_sa_way.sv
// One cache way: per-set valid/dirty/tag/line storage with asynchronous
// read, tag compare, byte-enable word merge on store hits and whole-line
// install on refill. Refill has priority over a store in the same cycle.
module dcache_sa_way
    import dcache_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int SETS   = 32,
    parameter int TAG_W  = 22,
    localparam int IDX_W  = idx_w(SETS),
    localparam int WSEL_W = off_w(LINE_W) - 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              hit_o,
    output logic              valid_o,
    output logic              dirty_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic [LINE_W-1:0] line_o,
    input  logic              wr_en_i,
    input  logic [WSEL_W-1:0] wsel_i,
    input  logic [3:0]        be_i,
    input  logic [31:0]       wdata_i,
    input  logic              fill_en_i,
    input  logic [LINE_W-1:0] fill_line_i
);

    logic [SETS-1:0]   valid_q, valid_d;
    logic [SETS-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]  tag_q  [SETS];
    logic [TAG_W-1:0]  tag_d  [SETS];
    logic [LINE_W-1:0] line_q [SETS];
    logic [LINE_W-1:0] line_d [SETS];

    assign valid_o = valid_q[idx_i];
    assign dirty_o = dirty_q[idx_i];
    assign tag_o   = tag_q[idx_i];
    assign line_o  = line_q[idx_i];
    assign hit_o   = valid_q[idx_i] && (tag_q[idx_i] == tag_i);

    // Next-state of the selected set: line install on refill, else byte merge on store hit.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        line_d  = line_q;
        if (fill_en_i) begin
            line_d[idx_i]  = fill_line_i;
            tag_d[idx_i]   = tag_i;
            valid_d[idx_i] = 1'b1;
            dirty_d[idx_i] = 1'b0;
        end else if (wr_en_i) begin
            for (int b = 0; b < 4; b++) begin
                if (be_i[b]) begin
                    line_d[idx_i][{wsel_i, 2'(b), 3'b000} +: 8] = wdata_i[{2'(b), 3'b000} +: 8];
                end
            end
            dirty_d[idx_i] = 1'b1;
        end
    end

    // Storage registers; tags and lines clear too so outputs are 0 out of reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
            for (int s = 0; s < SETS; s++) begin
                tag_q[s]  <= '0;
                line_q[s] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            line_q  <= line_d;
        end
    end

endmodule

// File: rtl/dcache_sa.sv
// 2-way set-associative, write-back, write-allocate data cache.
// Hits complete in one cycle; misses stall the pipeline while the FSM
// writes back a dirty victim and refills the line.
// Optional build macro DCACHE_STATS_EN: enables hit/miss statistics
// counters; without it hit_cnt_o/miss_cnt_o read 0.
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | serve hits; a missing request latches the victim way
// MISS      | decide write-back (victim valid & dirty) or plain refill
// WRITEBACK | victim line out to memory, wait for ack
// REFILL    | read requested line, install into victim way on ack
// DONE      | one settle cycle; the retried access then hits
module dcache_sa
    import dcache_pkg::*;
#(
    parameter int LINE_W = 256,
    parameter int SETS   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [LINE_W-1:0] mem_data_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [31:0]       p1_data_i,
    input  logic [3:0]        p1_be_i,
    input  logic              p1_MemRead_i,
    input  logic              p1_MemWrite_i,
    output logic [31:0]       p1_data_o,
    output logic              p1_stall_o,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
);

    localparam int OFF_W  = off_w(LINE_W);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, LINE_W, SETS);
    localparam int WSEL_W = OFF_W - 2;

    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  tag;
    logic [WSEL_W-1:0] wsel;
    logic              unused_addr_lsb;
    logic              req;
    logic              is_write;

    assign idx             = p1_addr_i[OFF_W +: IDX_W];
    assign tag             = p1_addr_i[ADDR_W-1 -: TAG_W];
    assign wsel            = p1_addr_i[OFF_W-1:2];
    assign unused_addr_lsb = ^p1_addr_i[1:0];
    assign req             = p1_MemRead_i | p1_MemWrite_i;
    assign is_write        = p1_MemWrite_i;

    state_t      state_q, state_d;
    logic        victim_q, victim_d;
    logic        mem_enable_q, mem_enable_d;
    logic        mem_write_q, mem_write_d;
    logic [SETS-1:0] lru_q, lru_d;

    logic [1:0]        way_hit;
    logic [1:0]        way_valid;
    logic [1:0]        way_dirty;
    logic [TAG_W-1:0]  way_tag  [2];
    logic [LINE_W-1:0] way_line [2];
    logic [1:0]        way_wr;
    logic [1:0]        way_fill;

    logic              hit;
    logic              victim_sel;
    logic              victim_cur;
    logic [LINE_W-1:0] hit_line;
    logic              fill_now;

    assign hit      = |way_hit;
    assign fill_now = (state_q == S_REFILL) && mem_ack_i;
    assign way_wr   = {2{req & is_write}} & way_hit;
    assign way_fill = {fill_now & victim_q, fill_now & ~victim_q};

    dcache_sa_way #(
        .LINE_W (LINE_W),
        .SETS   (SETS),
        .TAG_W  (TAG_W)
    ) u_way0 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (idx),
        .tag_i       (tag),
        .hit_o       (way_hit[0]),
        .valid_o     (way_valid[0]),
        .dirty_o     (way_dirty[0]),
        .tag_o       (way_tag[0]),
        .line_o      (way_line[0]),
        .wr_en_i     (way_wr[0]),
        .wsel_i      (wsel),
        .be_i        (p1_be_i),
        .wdata_i     (p1_data_i),
        .fill_en_i   (way_fill[0]),
        .fill_line_i (mem_data_i)
    );

    dcache_sa_way #(
        .LINE_W (LINE_W),
        .SETS   (SETS),
        .TAG_W  (TAG_W)
    ) u_way1 (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .idx_i       (idx),
        .tag_i       (tag),
        .hit_o       (way_hit[1]),
        .valid_o     (way_valid[1]),
        .dirty_o     (way_dirty[1]),
        .tag_o       (way_tag[1]),
        .line_o      (way_line[1]),
        .wr_en_i     (way_wr[1]),
        .wsel_i      (wsel),
        .be_i        (p1_be_i),
        .wdata_i     (p1_data_i),
        .fill_en_i   (way_fill[1]),
        .fill_line_i (mem_data_i)
    );

    // Victim choice: first invalid way (way0 first), else the LRU way of the set.
    always_comb begin
        victim_sel = lru_q[idx];
        if (!way_valid[0]) begin
            victim_sel = 1'b0;
        end else if (!way_valid[1]) begin
            victim_sel = 1'b1;
        end
        victim_cur = (state_q == S_IDLE) ? victim_sel : victim_q;
    end

    // Load data and memory-side outputs.
    always_comb begin
        hit_line   = way_hit[1] ? way_line[1] : way_line[0];
        p1_data_o  = hit ? hit_line[{wsel, 5'b00000} +: 32] : 32'h0;
        p1_stall_o = req & ~hit;
        mem_data_o = way_line[victim_cur];
        if (state_q == S_WRITEBACK) begin
            mem_addr_o = {way_tag[victim_q], idx, {OFF_W{1'b0}}};
        end else begin
            mem_addr_o = {tag, idx, {OFF_W{1'b0}}};
        end
    end

    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;

    // Miss-handling FSM; the memory request lines are registered alongside the state.
    always_comb begin
        state_d      = state_q;
        victim_d     = victim_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        case (state_q)
            S_IDLE: begin
                if (req && !hit) begin
                    state_d  = S_MISS;
                    victim_d = victim_sel;
                end
            end
            S_MISS: begin
                mem_enable_d = 1'b1;
                if (way_valid[victim_q] && way_dirty[victim_q]) begin
                    state_d     = S_WRITEBACK;
                    mem_write_d = 1'b1;
                end else begin
                    state_d     = S_REFILL;
                    mem_write_d = 1'b0;
                end
            end
            S_WRITEBACK: begin
                if (mem_ack_i) begin
                    state_d     = S_REFILL;
                    mem_write_d = 1'b0;
                end
            end
            S_REFILL: begin
                if (mem_ack_i) begin
                    state_d      = S_DONE;
                    mem_enable_d = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d      = S_IDLE;
                mem_enable_d = 1'b0;
                mem_write_d  = 1'b0;
            end
        endcase
    end

    // LRU bit of the accessed set points away from the way that just hit.
    always_comb begin
        lru_d = lru_q;
        if (req && hit) begin
            lru_d[idx] = ~way_hit[1];
        end
    end

    // FSM, victim and LRU registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= S_IDLE;
            victim_q     <= 1'b0;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            lru_q        <= '0;
        end else begin
            state_q      <= state_d;
            victim_q     <= victim_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            lru_q        <= lru_d;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;
    logic        retry_q, retry_d;

    // Saturating counters; the retried access right after DONE is not a new hit.
    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        retry_d    = (state_q == S_DONE);
        if (state_q == S_IDLE && req) begin
            if (hit) begin
                if (!retry_q && hit_cnt_q != 32'hFFFF_FFFF) begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                end
            end else if (miss_cnt_q != 32'hFFFF_FFFF) begin
                miss_cnt_d = miss_cnt_q + 32'd1;
            end
        end
    end

    // Statistics registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            retry_q    <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            retry_q    <= retry_d;
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = 32'h0;
    assign miss_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_dcache_sa.sv
// Directed bench for dcache_sa: table of accesses with hand-computed data
// and stall counts, a behavioural line memory with fixed ack latency, and
// hand sequences for eviction order, reset during refill, hit counting
// and spurious acks.
module tb_dcache_sa;

    localparam int LINE_W = 256;
    localparam int SETS   = 32;
    localparam int ADDR_W = 32;
    localparam int LAT    = 3;
`ifdef DCACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [LINE_W-1:0] mem_data_i;
    logic              mem_ack_i;
    logic [LINE_W-1:0] mem_data_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_enable_o;
    logic              mem_write_o;
    logic [ADDR_W-1:0] p1_addr_i;
    logic [31:0]       p1_data_i;
    logic [3:0]        p1_be_i;
    logic              p1_MemRead_i;
    logic              p1_MemWrite_i;
    logic [31:0]       p1_data_o;
    logic              p1_stall_o;
    logic [31:0]       hit_cnt_o;
    logic [31:0]       miss_cnt_o;

    logic resp_ack;
    logic spur_ack;
    assign mem_ack_i = resp_ack | spur_ack;

    always #5 clk_i = ~clk_i;

    dcache_sa #(.LINE_W(LINE_W), .SETS(SETS), .ADDR_W(ADDR_W)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .mem_data_i    (mem_data_i),
        .mem_ack_i     (mem_ack_i),
        .mem_data_o    (mem_data_o),
        .mem_addr_o    (mem_addr_o),
        .mem_enable_o  (mem_enable_o),
        .mem_write_o   (mem_write_o),
        .p1_addr_i     (p1_addr_i),
        .p1_data_i     (p1_data_i),
        .p1_be_i       (p1_be_i),
        .p1_MemRead_i  (p1_MemRead_i),
        .p1_MemWrite_i (p1_MemWrite_i),
        .p1_data_o     (p1_data_o),
        .p1_stall_o    (p1_stall_o),
        .hit_cnt_o     (hit_cnt_o),
        .miss_cnt_o    (miss_cnt_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Behavioural line memory: untouched words read as (byte address ^ 0x10000000).
    logic [LINE_W-1:0] mem_model [logic [31:0]];

    typedef struct {
        logic [31:0] addr;
        logic        wr;
    } txn_t;
    txn_t log_q[$];

    function automatic logic [LINE_W-1:0] get_line(input logic [31:0] la);
        logic [LINE_W-1:0] l;
        if (mem_model.exists(la)) return mem_model[la];
        for (int w = 0; w < LINE_W / 32; w++) begin
            l[w*32 +: 32] = (la + 32'(w * 4)) ^ 32'h1000_0000;
        end
        return l;
    endfunction

    // Memory responder: ack LAT cycles into each request phase.
    initial begin
        int cnt;
        cnt        = 0;
        resp_ack   = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk_i);
            if (mem_enable_o && rst_i) begin
                cnt++;
                if (cnt == LAT) begin
                    resp_ack = 1'b1;
                    cnt      = 0;
                    if (mem_write_o) begin
                        mem_model[mem_addr_o] = mem_data_o;
                        log_q.push_back('{mem_addr_o, 1'b1});
                    end else begin
                        mem_data_i = get_line(mem_addr_o);
                        log_q.push_back('{mem_addr_o, 1'b0});
                    end
                end else begin
                    resp_ack = 1'b0;
                end
            end else begin
                resp_ack = 1'b0;
                cnt      = 0;
            end
        end
    end

    // One pipeline access; counts stall cycles, holds the retry cycle after a miss.
    task automatic do_access(input logic [31:0] a, input logic rd, input logic wr,
                             input logic [3:0] be, input logic [31:0] wd,
                             output int stalls, output logic [31:0] rdata);
        @(negedge clk_i);
        p1_addr_i     = a;
        p1_MemRead_i  = rd;
        p1_MemWrite_i = wr;
        p1_be_i       = be;
        p1_data_i     = wd;
        #1;
        stalls = 0;
        while (p1_stall_o && stalls < 100) begin
            stalls++;
            @(negedge clk_i);
            #1;
        end
        if (stalls >= 100) begin
            checks++;
            errors++;
            $display("FAIL stall_timeout addr=%h stalls=%0d limit=100", a, stalls);
        end
        rdata = p1_data_o;
        if (stalls > 0) begin
            @(negedge clk_i);
            #1;
            rdata = p1_data_o;
        end
    endtask

    task automatic idle_bus();
        @(negedge clk_i);
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
        p1_be_i       = 4'h0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic        wr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_stalls;
    } vec_t;

    vec_t vecs[18];
    txn_t exp_log[8];

    initial begin
        int          st;
        logic [31:0] rd_v;
        int          exp_hits;
        int          exp_miss;
        int          waited;

        vecs[0]  = '{32'h0000_0040, 1'b1, 1'b0, 4'h0, 32'h0,          32'h1000_0040, 5};
        vecs[1]  = '{32'h0000_0044, 1'b1, 1'b0, 4'h0, 32'h0,          32'h1000_0044, 0};
        vecs[2]  = '{32'h0000_0048, 1'b0, 1'b1, 4'hF, 32'h1122_3344,  32'h0,         0};
        vecs[3]  = '{32'h0000_0048, 1'b1, 1'b0, 4'h0, 32'h0,          32'h1122_3344, 0};
        vecs[4]  = '{32'h0000_0048, 1'b0, 1'b1, 4'h3, 32'hDEAD_BEEF,  32'h0,         0};
        vecs[5]  = '{32'h0000_0048, 1'b1, 1'b0, 4'h0, 32'h0,          32'h1122_BEEF, 0};
        vecs[6]  = '{32'h0000_005C, 1'b0, 1'b1, 4'hC, 32'hAABB_CCDD,  32'h0,         0};
        vecs[7]  = '{32'h0000_005C, 1'b1, 1'b0, 4'h0, 32'h0,          32'hAABB_005C, 0};
        vecs[8]  = '{32'h0000_0440, 1'b1, 1'b0, 4'h0, 32'h0,          32'h1000_0440, 5};
        vecs[9]  = '{32'h0000_0444, 1'b0, 1'b1, 4'hF, 32'h5566_7788,  32'h0,         0};
        vecs[10] = '{32'h0000_0040, 1'b1, 1'b0, 4'h0, 32'h0,          32'h1000_0040, 0};
        vecs[11] = '{32'h0000_0840, 1'b1, 1'b0, 4'h0, 32'h0,          32'h1000_0840, 8};
        vecs[12] = '{32'h0000_0444, 1'b1, 1'b0, 4'h0, 32'h0,          32'h5566_7788, 8};
        vecs[13] = '{32'h0000_0048, 1'b1, 1'b0, 4'h0, 32'h0,          32'h1122_BEEF, 5};
        vecs[14] = '{32'h0000_005C, 1'b1, 1'b0, 4'h0, 32'h0,          32'hAABB_005C, 0};
        vecs[15] = '{32'h0000_005C, 1'b1, 1'b1, 4'h1, 32'h0000_00EE,  32'h0,         0};
        vecs[16] = '{32'h0000_005C, 1'b1, 1'b0, 4'h0, 32'h0,          32'hAABB_00EE, 0};
        vecs[17] = '{32'hFFFF_FFFC, 1'b1, 1'b0, 4'h0, 32'h0,          32'hEFFF_FFFC, 5};

        exp_log[0] = '{32'h0000_0040, 1'b0};
        exp_log[1] = '{32'h0000_0440, 1'b0};
        exp_log[2] = '{32'h0000_0440, 1'b1};
        exp_log[3] = '{32'h0000_0840, 1'b0};
        exp_log[4] = '{32'h0000_0040, 1'b1};
        exp_log[5] = '{32'h0000_0440, 1'b0};
        exp_log[6] = '{32'h0000_0040, 1'b0};
        exp_log[7] = '{32'hFFFF_FFE0, 1'b0};

        rst_i         = 1'b0;
        spur_ack      = 1'b0;
        p1_addr_i     = '0;
        p1_data_i     = '0;
        p1_be_i       = '0;
        p1_MemRead_i  = 1'b0;
        p1_MemWrite_i = 1'b0;
        repeat (3) @(negedge clk_i);

        chk("rst_mem_enable", 32'(mem_enable_o), 32'h0);
        chk("rst_mem_write",  32'(mem_write_o),  32'h0);
        chk("rst_mem_addr",   mem_addr_o,        32'h0);
        chk("rst_mem_data",   mem_data_o[31:0] | mem_data_o[LINE_W-1 -: 32], 32'h0);
        chk("rst_p1_data",    p1_data_o,         32'h0);
        chk("rst_stall",      32'(p1_stall_o),   32'h0);
        chk("rst_hit_cnt",    hit_cnt_o,         32'h0);
        chk("rst_miss_cnt",   miss_cnt_o,        32'h0);
        rst_i = 1'b1;

        exp_hits = 0;
        exp_miss = 0;
        for (int i = 0; i < 18; i++) begin
            do_access(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].be, vecs[i].wdata, st, rd_v);
            chk($sformatf("vec%0d_stalls", i), 32'(st), 32'(vecs[i].exp_stalls));
            if (vecs[i].rd && !vecs[i].wr) begin
                chk($sformatf("vec%0d_data", i), rd_v, vecs[i].exp_data);
            end
            if (vecs[i].exp_stalls > 0) exp_miss++;
            else exp_hits++;
        end
        idle_bus();
        repeat (2) @(negedge clk_i);
        #1;
        chk("tbl_hit_cnt",  hit_cnt_o,  STATS ? 32'(exp_hits) : 32'h0);
        chk("tbl_miss_cnt", miss_cnt_o, STATS ? 32'(exp_miss) : 32'h0);
        chk("tbl_idle_enable", 32'(mem_enable_o), 32'h0);

        chk("log_len", 32'(log_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (i < log_q.size()) begin
                chk($sformatf("log%0d_addr", i), log_q[i].addr, exp_log[i].addr);
                chk($sformatf("log%0d_wr", i), 32'(log_q[i].wr), 32'(exp_log[i].wr));
            end
        end

        // Reset while refilling 0x80: request drops at once and the line is not kept.
        @(negedge clk_i);
        p1_addr_i     = 32'h0000_0080;
        p1_MemRead_i  = 1'b1;
        p1_MemWrite_i = 1'b0;
        #1;
        waited = 0;
        while (!(mem_enable_o && !mem_write_o) && waited < 20) begin
            waited++;
            @(negedge clk_i);
            #1;
        end
        chk("refill_reached", 32'(mem_enable_o && !mem_write_o), 32'h1);
        rst_i = 1'b0;
        #1;
        chk("rst_mid_refill_enable", 32'(mem_enable_o), 32'h0);
        p1_MemRead_i = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        chk("post_rst_hit_cnt",  hit_cnt_o,  32'h0);
        chk("post_rst_miss_cnt", miss_cnt_o, 32'h0);

        do_access(32'h0000_0080, 1'b1, 1'b0, 4'h0, 32'h0, st, rd_v);
        chk("rerun_stalls", 32'(st), 32'd5);
        chk("rerun_data",   rd_v,    32'h1000_0080);

        for (int i = 0; i < 10; i++) begin
            do_access(32'h0000_0080 + 32'((i % 8) * 4), 1'b1, 1'b0, 4'h0, 32'h0, st, rd_v);
            chk($sformatf("hit%0d_stalls", i), 32'(st), 32'h0);
            chk($sformatf("hit%0d_data", i), rd_v, (32'h0000_0080 + 32'((i % 8) * 4)) ^ 32'h1000_0000);
        end
        idle_bus();
        #1;
        chk("ten_hits_cnt", hit_cnt_o,  STATS ? 32'd10 : 32'h0);
        chk("one_miss_cnt", miss_cnt_o, STATS ? 32'd1  : 32'h0);

        // Spurious ack while idle must not start or advance anything.
        spur_ack = 1'b1;
        @(negedge clk_i);
        spur_ack = 1'b0;
        #1;
        chk("spur_enable", 32'(mem_enable_o), 32'h0);
        chk("spur_write",  32'(mem_write_o),  32'h0);
        do_access(32'h0000_0084, 1'b1, 1'b0, 4'h0, 32'h0, st, rd_v);
        chk("spur_hit_stalls", 32'(st), 32'h0);
        chk("spur_hit_data",   rd_v,    32'h1000_0084);
        idle_bus();
        #1;
        chk("spur_hit_cnt",  hit_cnt_o,  STATS ? 32'd11 : 32'h0);
        chk("spur_miss_cnt", miss_cnt_o, STATS ? 32'd1  : 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time_limit_reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
